// File: rtl/clock_gen_pkg.sv
// Shared constants, state encoding and ratio clamp for the clock_gen divider.
package clock_gen_pkg;

    localparam int CG_DIV_W       = 16;
    localparam int CG_DEFAULT_DIV = 10;
    localparam int MIN_DIV        = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ratios of 0 or 1 cannot form a high and a low phase, so they become 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'(MIN_DIV)) ? 32'(MIN_DIV) : n;
    endfunction

endpackage

// File: rtl/clock_gen_ratio_reg.sv
// Pending/active divide-ratio registers. A load is held as pending and only
// becomes active when the top signals a period boundary (wrap or start).
module clock_gen_ratio_reg
    import clock_gen_pkg::*;
#(
    parameter int DIV_W       = CG_DIV_W,
    parameter int DEFAULT_DIV = CG_DEFAULT_DIV
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             div_load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             swap_i,
    output logic [DIV_W-1:0] active_o
);

    logic [DIV_W-1:0] pending_q, pending_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic             pendingValid_q, pendingValid_d;
    logic [DIV_W-1:0] divClamped;

    assign divClamped = DIV_W'(clamp_div(32'(div_i)));

    // Swap in the pending ratio at a boundary; a load in the same cycle stays pending.
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pendingValid_d = pendingValid_q;
        if (swap_i && pendingValid_q) begin
            active_d       = pending_q;
            pendingValid_d = 1'b0;
        end
        if (div_load_i) begin
            pending_d      = divClamped;
            pendingValid_d = 1'b1;
        end
    end

    // Ratio state registers, reset to the default ratio with nothing pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q       <= DIV_W'(DEFAULT_DIV);
            pending_q      <= DIV_W'(DEFAULT_DIV);
            pendingValid_q <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pendingValid_q <= pendingValid_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/clock_gen.sv
// Programmable clock divider: registered divided clock, rising-edge tick and
// running flag, all produced in the clk domain from a 0..N-1 period counter.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int DIV_W       = CG_DIV_W,
    parameter int DEFAULT_DIV = CG_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic             swapRatio;
    logic [DIV_W-1:0] activeDiv;
    logic [DIV_W-1:0] halfN;
    logic [DIV_W-1:0] cntNext;
    logic             lastCnt;

    clock_gen_ratio_reg #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ratio (
        .clk_i      (clk),
        .rst_i      (rst),
        .div_load_i (div_load),
        .div_i      (div),
        .swap_i     (swapRatio),
        .active_o   (activeDiv)
    );

    assign halfN   = activeDiv >> 1;
    assign cntNext = cnt_q + DIV_W'(1);
    assign lastCnt = (cnt_q == activeDiv - DIV_W'(1));

    // Next-state logic: start, count, wrap-or-stop; clk_out follows the next count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clkOut_d  = clkOut_q;
        tick_d    = 1'b0;
        swapRatio = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                clkOut_d = 1'b0;
                if (en) begin
                    state_d   = ST_RUN;
                    clkOut_d  = 1'b1;
                    tick_d    = 1'b1;
                    swapRatio = 1'b1;
                end
            end
            ST_RUN: begin
                if (lastCnt) begin
                    swapRatio = 1'b1;
                    cnt_d     = '0;
                    if (en) begin
                        clkOut_d = 1'b1;
                        tick_d   = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        clkOut_d = 1'b0;
                    end
                end else begin
                    cnt_d    = cntNext;
                    clkOut_d = (cntNext < halfN);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                clkOut_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            clkOut_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clkOut_q <= clkOut_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_out = clkOut_q;
    assign tick    = tick_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: directed scenarios with literal
// expectations plus randomized traffic against a period-position model.
module tb_clock_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        div_load;
    logic        clk_out;
    logic        tick;
    logic        running;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn    = 0;

    // Model: whether periods run, position within the period, ratios.
    int mRun  = 0;
    int mPos  = 0;
    int mN    = 10;
    int mPend = 10;
    int mFlag = 0;

    clock_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one clk edge from the inputs present at that edge.
    task automatic modelStep();
        if (rst) begin
            mRun = 0; mPos = 0; mN = 10; mPend = 10; mFlag = 0;
        end else begin
            if (mRun == 0) begin
                if (en) begin
                    mRun = 1;
                    mPos = 0;
                    if (mFlag != 0) begin mN = mPend; mFlag = 0; end
                end
            end else if (mPos == mN - 1) begin
                if (mFlag != 0) begin mN = mPend; mFlag = 0; end
                mPos = 0;
                if (!en) mRun = 0;
            end else begin
                mPos++;
            end
            if (div_load) begin
                mPend = (int'(div) < 2) ? 2 : int'(div);
                mFlag = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Every cycle: outputs must match the period position held by the model.
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("model clk_out", int'(clk_out), (mRun != 0 && mPos < mN / 2) ? 1 : 0);
                checkOutput("model tick", int'(tick), (mRun != 0 && mPos == 0) ? 1 : 0);
                checkOutput("model running", int'(running), mRun);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [15:0] d, input logic l);
        rst      = r;
        en       = e;
        div      = d;
        div_load = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int highCnt;
        int tickCnt;
        int toggles;
        int steps;
        logic prevClk;
        logic [5:0] pattern;
        logic [5:0] tickPat;

        rst = 1'b1; en = 1'b0; div = 16'd10; div_load = 1'b0;
        applyStimulus(1, 0, 16'd10, 0);
        applyStimulus(1, 0, 16'd10, 0);
        checkEn = 1;
        checkOutput("reset clk_out", int'(clk_out), 0);
        checkOutput("reset tick", int'(tick), 0);
        checkOutput("reset running", int'(running), 0);

        // Default ratio: first rise one cycle after en, 5 high / 5 low.
        applyStimulus(0, 1, 16'd10, 0);
        checkOutput("start clk_out", int'(clk_out), 1);
        checkOutput("start tick", int'(tick), 1);
        checkOutput("start running", int'(running), 1);
        highCnt = 0; tickCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 16'd10, 0);
            highCnt += int'(clk_out);
            tickCnt += int'(tick);
        end
        checkOutput("N10 high cycles", highCnt, 5);
        checkOutput("N10 ticks", tickCnt, 1);

        // Mid-period load of 3: period of 10 finishes, then 1 high / 2 low.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'd10, 0);
        applyStimulus(0, 1, 16'd3, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'd3, 0);
        checkOutput("N10 period still high-free at pos9", int'(clk_out), 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 16'd3, 0);
            pattern[5 - i] = clk_out;
            tickPat[5 - i] = tick;
        end
        checkOutput("N3 clk_out pattern", int'(pattern), 6'b100100);
        checkOutput("N3 tick pattern", int'(tickPat), 6'b100100);

        // Ratios 0 and 1 clamp to 2: clk_out toggles each cycle.
        applyStimulus(0, 1, 16'd0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'd0, 0);
        applyStimulus(0, 1, 16'd1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 16'd1, 0);
        toggles = 0;
        prevClk = clk_out;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 16'd1, 0);
            if (clk_out != prevClk) toggles++;
            prevClk = clk_out;
        end
        checkOutput("N2 toggles in 8 cycles", toggles, 8);

        // Stop request at cnt=4 of N=8: period finishes after 8 cycles total.
        applyStimulus(0, 1, 16'd8, 1);
        steps = 0;
        while (steps < 40 && !(mRun != 0 && mPos == 0 && mN == 8)) begin
            applyStimulus(0, 1, 16'd8, 0);
            steps++;
        end
        checkOutput("reach N8 period start", (steps < 40) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'd8, 0);
        steps = 0;
        do begin
            applyStimulus(0, 0, 16'd8, 0);
            steps++;
        end while (running && steps < 20);
        checkOutput("stop period length", 4 + steps, 8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 16'd8, 0);
            checkOutput("idle clk_out held low", int'(clk_out), 0);
        end
        applyStimulus(0, 1, 16'd8, 0);
        checkOutput("restart tick", int'(tick), 1);
        checkOutput("restart clk_out", int'(clk_out), 1);

        // Reset during the high phase with en and a load: reset wins, ratio back to 10.
        applyStimulus(0, 1, 16'd8, 0);
        applyStimulus(0, 1, 16'd8, 0);
        applyStimulus(1, 1, 16'd5, 1);
        checkOutput("rst clk_out", int'(clk_out), 0);
        checkOutput("rst tick", int'(tick), 0);
        checkOutput("rst running", int'(running), 0);
        applyStimulus(0, 1, 16'd5, 0);
        checkOutput("post-rst tick", int'(tick), 1);
        highCnt = 0; tickCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 16'd5, 0);
            highCnt += int'(clk_out);
            tickCnt += int'(tick);
        end
        checkOutput("post-rst N10 high cycles", highCnt, 5);
        checkOutput("post-rst N10 ticks", tickCnt, 1);

        // Long run at N=10: 1000 cycles hold exactly 100 ticks.
        tickCnt = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 1, 16'd10, 0);
            tickCnt += int'(tick);
        end
        checkOutput("1000-cycle tick count", tickCnt, 100);

        // Randomized en / loads / occasional reset against the model.
        for (int i = 0; i < 4000; i++) begin
            logic rr, ee, ll;
            logic [15:0] dd;
            rr = ($urandom_range(0, 399) == 0);
            ee = ($urandom_range(0, 9) != 0);
            ll = ($urandom_range(0, 19) == 0);
            dd = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(13, 40))
                                              : 16'($urandom_range(0, 12));
            applyStimulus(rr, ee, dd, ll);
        end

        applyStimulus(0, 0, 16'd10, 0);
        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
